letc_core_stage_e2: RTL and testbench
=====================================

Name: letc_core_stage_e2

Overview:
Second execute stage of the LETC core, directly upstream of the writeback stage. It consumes e1_to_e2_s from E1 and performs data-memory access: store lane and mask generation, request/response handshake, and load alignment with sign/zero extension. It emits a registered e2_to_w_s to the writeback stage and owns the stall/flush/ready handshake for this slot.

Parameters:
None. All widths come from letc_pkg / letc_core_pkg (word_t = 32, reg_idx_t = 5).

Ports:
i_clk  in  1  core clock
i_rst  in  1  synchronous, active-high reset
o_stage_ready  out  1  stage can accept a new instruction this cycle
i_stage_flush  in  1  kill the instruction held or arriving in E2
i_stage_stall  in  1  block acceptance of a new instruction
i_e1_to_e2  in  e1_to_e2_s  valid, rd_idx, rd_we, alu_result, mem_op{NONE,LOAD,STORE}, mem_size{B,H,W}, mem_unsigned, store_data, csr fields
o_e2_to_w  out  e2_to_w_s  valid, rd_idx, rd_we, rd_wdata, csr fields, trap_misaligned
o_dmem_req_valid  out  1  request valid
i_dmem_req_ready  in  1  request accepted when valid && ready
o_dmem_req_we  out  1  1 = store
o_dmem_req_addr  out  32  word-aligned address, alu_result with [1:0] forced to 0
o_dmem_req_wdata  out  32  lane-replicated store data
o_dmem_req_wmask  out  4  byte enables
i_dmem_rsp_valid  in  1  load response valid, one cycle, in order
i_dmem_rsp_rdata  in  32  load data word

Behaviour:
- Reset (i_rst high at a rising edge): state = IDLE; o_e2_to_w.valid = 0 and all other o_e2_to_w fields = 0; o_dmem_req_valid = 0; held instruction cleared. Reset mid-transaction abandons it; no response is drained.
- FSM states: IDLE, REQ, WAIT_RSP, DRAIN.
- o_stage_ready = (state == IDLE).
- Accept condition: IDLE && i_e1_to_e2.valid && !i_stage_stall && !i_stage_flush.
- Accept, mem_op = NONE: o_e2_to_w loads at the same edge with valid = 1 and rd_wdata = alu_result. One-cycle latency. Stay in IDLE; back-to-back accepts are allowed every cycle.
- Accept, mem_op = LOAD/STORE: latch the instruction and go to REQ. o_e2_to_w.valid = 0 at the next edge.
- o_e2_to_w.valid is a one-cycle pulse per instruction. It is 0 in every cycle with no completion, including stall bubbles.
- REQ: o_dmem_req_valid = 1. Address, we, wdata and wmask stay stable until handshake.
  - Store handshake: o_e2_to_w.valid = 1 at that edge with rd_we = 0; go to IDLE.
  - Load handshake: go to WAIT_RSP.
  - A response is never returned in the same cycle as its request.
- WAIT_RSP: on i_dmem_rsp_valid, load o_e2_to_w with valid = 1 and the aligned, extended data in rd_wdata; go to IDLE.
- Store formatting (a = addr[1:0]):
  - SB: wmask = 4'b0001 << a; wdata = {4{data[7:0]}}.
  - SH: wmask = 4'b0011 << {a[1],1'b0}; wdata = {2{data[15:0]}}.
  - SW: wmask = 4'hF; wdata = data.
- Load formatting:
  - LB/LBU: select byte a.
  - LH/LHU: select half a[1].
  - LW: full word.
  - Sign-extend unless mem_unsigned.
- Flush:
  - In IDLE: no accept; o_e2_to_w.valid = 0 next edge.
  - In REQ: o_dmem_req_valid drops the same cycle, and the unaccepted request is withdrawn (the dmem interface permits this); go to IDLE. If the handshake completes in the same cycle as a flush, a store is treated as performed and a load goes to DRAIN; in both cases the output valid is suppressed.
  - In WAIT_RSP: go to DRAIN.
  - In DRAIN: wait for i_dmem_rsp_valid, discard the data, go to IDLE with no output.
- Stall: blocks acceptance only. In-flight REQ/WAIT_RSP/DRAIN proceed, and W is always ready.

Optional Feature:
Macro: LETC_CORE_E2_MISALIGN_CHECK_EN.
- Defined: an H access with a[0] = 1, or a W access with a != 0, issues no request. o_e2_to_w loads at the accept edge with valid = 1, trap_misaligned = 1, rd_we = 0; stay in IDLE.
- Undefined: trap_misaligned is tied to 0. Misaligned accesses ignore the offending low bits (H uses a[1], W uses aligned word) and proceed normally.

Test Plan:
- Reset: assert i_rst for 2 cycles mid-load -> o_e2_to_w.valid = 0, o_dmem_req_valid = 0, o_stage_ready = 1 on the first post-reset cycle.
- ALU pass-through: 3 back-to-back NONE ops, rd = 5/6/7, alu_result = 0x11/0x22/0x33 -> valid pulses on consecutive edges carrying those values.
- LB signed at addr 0x1003, rsp 0x80FF_0000, req_ready delayed 2 cycles -> req_addr = 0x1000, rd_wdata = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at addr 0x2002, data 0x0000_BEEF -> wmask = 4'b1100, wdata = 0xBEEF_BEEF, output valid with rd_we = 0 at the handshake edge.
- Flush in WAIT_RSP, response 3 cycles later -> no output valid, state returns to IDLE after rsp, next ALU op completes normally.
- With LETC_CORE_E2_MISALIGN_CHECK_EN defined: LW at 0x3001 -> no req_valid, trap_misaligned = 1; without it, req_addr = 0x3000 and the load completes.

Source files
------------

// File: rtl/letc_core_stage_e2.sv
// LETC core E2 stage: data-memory request/response handling, store lane formatting, load alignment.
// Optional build macro LETC_CORE_E2_MISALIGN_CHECK_EN enables misaligned-access traps.
module letc_core_stage_e2 (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_stage_ready,
    input  logic        i_stage_flush,
    input  logic        i_stage_stall,
    input  logic        i_e1_to_e2_valid,
    input  logic [4:0]  i_e1_to_e2_rd_idx,
    input  logic        i_e1_to_e2_rd_we,
    input  logic [31:0] i_e1_to_e2_alu_result,
    input  logic [1:0]  i_e1_to_e2_mem_op,
    input  logic [1:0]  i_e1_to_e2_mem_size,
    input  logic        i_e1_to_e2_mem_unsigned,
    input  logic [31:0] i_e1_to_e2_store_data,
    input  logic        i_e1_to_e2_csr_we,
    input  logic [11:0] i_e1_to_e2_csr_idx,
    input  logic [31:0] i_e1_to_e2_csr_wdata,
    output logic        o_e2_to_w_valid,
    output logic [4:0]  o_e2_to_w_rd_idx,
    output logic        o_e2_to_w_rd_we,
    output logic [31:0] o_e2_to_w_rd_wdata,
    output logic        o_e2_to_w_csr_we,
    output logic [11:0] o_e2_to_w_csr_idx,
    output logic [31:0] o_e2_to_w_csr_wdata,
    output logic        o_e2_to_w_trap_misaligned,
    output logic        o_dmem_req_valid,
    input  logic        i_dmem_req_ready,
    output logic        o_dmem_req_we,
    output logic [31:0] o_dmem_req_addr,
    output logic [31:0] o_dmem_req_wdata,
    output logic [3:0]  o_dmem_req_wmask,
    input  logic        i_dmem_rsp_valid,
    input  logic [31:0] i_dmem_rsp_rdata
);
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] SZ_B     = 2'd0;
    localparam logic [1:0] SZ_H     = 2'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DRAIN} state_e;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction
    logic trap_q;
`endif

    state_e      state_q;
    logic [4:0]  rd_idx_q;
    logic        rd_we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic        csr_we_q;
    logic [11:0] csr_idx_q;
    logic [31:0] csr_wdata_q;
    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wmask_q;
    logic        out_valid_q;
    logic [4:0]  out_rd_idx_q;
    logic        out_rd_we_q;
    logic [31:0] out_rd_wdata_q;
    logic        out_csr_we_q;
    logic [11:0] out_csr_idx_q;
    logic [31:0] out_csr_wdata_q;

    logic        accept;
    logic        hs;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] ld_data_d;

    assign accept    = (state_q == IDLE) && i_e1_to_e2_valid && !i_stage_stall && !i_stage_flush;
    assign wmask_d   = store_mask(i_e1_to_e2_mem_size, i_e1_to_e2_alu_result[1:0]);
    assign wdata_d   = store_lanes(i_e1_to_e2_mem_size, i_e1_to_e2_store_data);
    assign ld_data_d = load_align(size_q, uns_q, off_q, i_dmem_rsp_rdata);

    // A flush withdraws a pending request in the same cycle, before the memory can accept it.
    assign o_dmem_req_valid = (state_q == REQ) && !i_stage_flush;
    assign hs               = o_dmem_req_valid && i_dmem_req_ready;
    assign o_stage_ready    = (state_q == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            rd_idx_q        <= '0;
            rd_we_q         <= 1'b0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            off_q           <= '0;
            csr_we_q        <= 1'b0;
            csr_idx_q       <= '0;
            csr_wdata_q     <= '0;
            req_we_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            out_valid_q     <= 1'b0;
            out_rd_idx_q    <= '0;
            out_rd_we_q     <= 1'b0;
            out_rd_wdata_q  <= '0;
            out_csr_we_q    <= 1'b0;
            out_csr_idx_q   <= '0;
            out_csr_wdata_q <= '0;
`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
            trap_q          <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
            trap_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (i_e1_to_e2_mem_op == OP_NONE) begin
                            out_valid_q     <= 1'b1;
                            out_rd_idx_q    <= i_e1_to_e2_rd_idx;
                            out_rd_we_q     <= i_e1_to_e2_rd_we;
                            out_rd_wdata_q  <= i_e1_to_e2_alu_result;
                            out_csr_we_q    <= i_e1_to_e2_csr_we;
                            out_csr_idx_q   <= i_e1_to_e2_csr_idx;
                            out_csr_wdata_q <= i_e1_to_e2_csr_wdata;
                        end
`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
                        else if (misaligned(i_e1_to_e2_mem_size, i_e1_to_e2_alu_result[1:0])) begin
                            out_valid_q     <= 1'b1;
                            trap_q          <= 1'b1;
                            out_rd_idx_q    <= i_e1_to_e2_rd_idx;
                            out_rd_we_q     <= 1'b0;
                            out_rd_wdata_q  <= '0;
                            out_csr_we_q    <= 1'b0;
                            out_csr_idx_q   <= i_e1_to_e2_csr_idx;
                            out_csr_wdata_q <= i_e1_to_e2_csr_wdata;
                        end
`endif
                        else begin
                            rd_idx_q    <= i_e1_to_e2_rd_idx;
                            rd_we_q     <= i_e1_to_e2_rd_we;
                            size_q      <= i_e1_to_e2_mem_size;
                            uns_q       <= i_e1_to_e2_mem_unsigned;
                            off_q       <= i_e1_to_e2_alu_result[1:0];
                            csr_we_q    <= i_e1_to_e2_csr_we;
                            csr_idx_q   <= i_e1_to_e2_csr_idx;
                            csr_wdata_q <= i_e1_to_e2_csr_wdata;
                            req_we_q    <= (i_e1_to_e2_mem_op == OP_STORE);
                            req_addr_q  <= {i_e1_to_e2_alu_result[31:2], 2'b00};
                            req_wdata_q <= wdata_d;
                            req_wmask_q <= (i_e1_to_e2_mem_op == OP_STORE) ? wmask_d : 4'h0;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_stage_flush) begin
                        state_q <= (hs && !req_we_q) ? DRAIN : IDLE;
                    end else if (hs) begin
                        if (req_we_q) begin
                            out_valid_q     <= 1'b1;
                            out_rd_idx_q    <= rd_idx_q;
                            out_rd_we_q     <= 1'b0;
                            out_rd_wdata_q  <= '0;
                            out_csr_we_q    <= csr_we_q;
                            out_csr_idx_q   <= csr_idx_q;
                            out_csr_wdata_q <= csr_wdata_q;
                            state_q         <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving with the flush is simply dropped; nothing remains to drain.
                    if (i_stage_flush) begin
                        state_q <= i_dmem_rsp_valid ? IDLE : DRAIN;
                    end else if (i_dmem_rsp_valid) begin
                        out_valid_q     <= 1'b1;
                        out_rd_idx_q    <= rd_idx_q;
                        out_rd_we_q     <= rd_we_q;
                        out_rd_wdata_q  <= ld_data_d;
                        out_csr_we_q    <= csr_we_q;
                        out_csr_idx_q   <= csr_idx_q;
                        out_csr_wdata_q <= csr_wdata_q;
                        state_q         <= IDLE;
                    end
                end
                DRAIN: begin
                    if (i_dmem_rsp_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_e2_to_w_valid     = out_valid_q;
    assign o_e2_to_w_rd_idx    = out_rd_idx_q;
    assign o_e2_to_w_rd_we     = out_rd_we_q;
    assign o_e2_to_w_rd_wdata  = out_rd_wdata_q;
    assign o_e2_to_w_csr_we    = out_csr_we_q;
    assign o_e2_to_w_csr_idx   = out_csr_idx_q;
    assign o_e2_to_w_csr_wdata = out_csr_wdata_q;
    assign o_dmem_req_we       = req_we_q;
    assign o_dmem_req_addr     = req_addr_q;
    assign o_dmem_req_wdata    = req_wdata_q;
    assign o_dmem_req_wmask    = req_wmask_q;
`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
    assign o_e2_to_w_trap_misaligned = trap_q;
`else
    assign o_e2_to_w_trap_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_letc_core_stage_e2.sv
// Directed testbench for letc_core_stage_e2: ALU pass-through, loads, stores, flush, stall, reset.
module tb_letc_core_stage_e2;
    localparam logic [1:0] OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stage_ready, flush, stall;
    logic        e1_valid, e1_rd_we, e1_uns, e1_csr_we;
    logic [4:0]  e1_rd_idx;
    logic [31:0] e1_alu, e1_sdata, e1_csr_wdata;
    logic [1:0]  e1_op, e1_size;
    logic [11:0] e1_csr_idx;
    logic        w_valid, w_rd_we, w_csr_we, w_trap;
    logic [4:0]  w_rd_idx;
    logic [31:0] w_rd_wdata, w_csr_wdata;
    logic [11:0] w_csr_idx;
    logic        req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wmask;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    letc_core_stage_e2 dut (
        .i_clk(clk), .i_rst(rst), .o_stage_ready(stage_ready),
        .i_stage_flush(flush), .i_stage_stall(stall),
        .i_e1_to_e2_valid(e1_valid), .i_e1_to_e2_rd_idx(e1_rd_idx), .i_e1_to_e2_rd_we(e1_rd_we),
        .i_e1_to_e2_alu_result(e1_alu), .i_e1_to_e2_mem_op(e1_op), .i_e1_to_e2_mem_size(e1_size),
        .i_e1_to_e2_mem_unsigned(e1_uns), .i_e1_to_e2_store_data(e1_sdata),
        .i_e1_to_e2_csr_we(e1_csr_we), .i_e1_to_e2_csr_idx(e1_csr_idx), .i_e1_to_e2_csr_wdata(e1_csr_wdata),
        .o_e2_to_w_valid(w_valid), .o_e2_to_w_rd_idx(w_rd_idx), .o_e2_to_w_rd_we(w_rd_we),
        .o_e2_to_w_rd_wdata(w_rd_wdata), .o_e2_to_w_csr_we(w_csr_we), .o_e2_to_w_csr_idx(w_csr_idx),
        .o_e2_to_w_csr_wdata(w_csr_wdata), .o_e2_to_w_trap_misaligned(w_trap),
        .o_dmem_req_valid(req_valid), .i_dmem_req_ready(req_ready), .o_dmem_req_we(req_we),
        .o_dmem_req_addr(req_addr), .o_dmem_req_wdata(req_wdata), .o_dmem_req_wmask(req_wmask),
        .i_dmem_rsp_valid(rsp_valid), .i_dmem_rsp_rdata(rsp_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sdata);
        e1_valid = 1'b1; e1_op = op; e1_size = size; e1_uns = uns;
        e1_rd_idx = rd; e1_rd_we = 1'b1; e1_alu = alu; e1_sdata = sdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", w_valid); end
        tests++; if (stage_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", stage_ready); end
        drive_op(OP_LOAD, SZ_W, 1'b0, 5'd4, 32'h0000_0100, 32'h0);
        tick(); e1_valid = 1'b0;
        tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_req got %b exp 1", req_valid); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL midload_reset_valid got %b exp 0", w_valid); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL midload_reset_req got %b exp 0", req_valid); end
        tests++; if (stage_ready !== 1'b1) begin fails++; $display("FAIL midload_reset_ready got %b exp 1", stage_ready); end
        tests++; if (w_rd_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", w_rd_wdata); end
    endtask

    task automatic test_alu_passthrough();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            drive_op(OP_NONE, SZ_W, 1'b0, 5'(5 + i), vals[i], 32'h0);
            tick();
            tests++; if (w_valid !== 1'b1 || w_rd_wdata !== vals[i] || w_rd_idx !== 5'(5 + i) || w_rd_we !== 1'b1)
                begin fails++; $display("FAIL alu_%0d got v=%b d=%h rd=%0d exp v=1 d=%h rd=%0d", i, w_valid, w_rd_wdata, w_rd_idx, vals[i], 5 + i); end
        end
        e1_valid = 1'b0; tick();
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL alu_bubble got %b exp 0", w_valid); end
    endtask

    task automatic test_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        req_ready = 1'b0;
        drive_op(OP_LOAD, size, uns, 5'd9, addr, 32'h0);
        tick(); e1_valid = 1'b0;
        tests++; if (req_valid !== 1'b1 || req_we !== 1'b0 || req_addr !== {addr[31:2], 2'b00} || stage_ready !== 1'b0)
            begin fails++; $display("FAIL load_req got v=%b we=%b a=%h exp v=1 we=0 a=%h", req_valid, req_we, req_addr, {addr[31:2], 2'b00}); end
        tick(); tick();
        tests++; if (req_valid !== 1'b1 || w_valid !== 1'b0) begin fails++; $display("FAIL load_req_hold got v=%b wv=%b exp 1/0", req_valid, w_valid); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL load_wait got req=%b exp 0", req_valid); end
        rsp_valid = 1'b1; rsp_rdata = rdata; tick(); rsp_valid = 1'b0;
        tests++; if (w_valid !== 1'b1 || w_rd_wdata !== exp || w_rd_idx !== 5'd9 || w_rd_we !== 1'b1)
            begin fails++; $display("FAIL load_data got v=%b d=%h exp v=1 d=%h", w_valid, w_rd_wdata, exp); end
        tick();
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL load_pulse got %b exp 0", w_valid); end
    endtask

    task automatic test_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        req_ready = 1'b0;
        drive_op(OP_STORE, size, 1'b0, 5'd3, addr, data);
        tick(); e1_valid = 1'b0;
        tests++; if (req_valid !== 1'b1 || req_we !== 1'b1 || req_wmask !== exp_mask || req_wdata !== exp_wdata || req_addr !== {addr[31:2], 2'b00})
            begin fails++; $display("FAIL store_req got m=%b d=%h a=%h exp m=%b d=%h", req_wmask, req_wdata, req_addr, exp_mask, exp_wdata); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        tests++; if (w_valid !== 1'b1 || w_rd_we !== 1'b0 || stage_ready !== 1'b1)
            begin fails++; $display("FAIL store_done got v=%b we=%b rdy=%b exp 1/0/1", w_valid, w_rd_we, stage_ready); end
    endtask

    task automatic test_flush_wait_rsp();
        drive_op(OP_LOAD, SZ_W, 1'b0, 5'd10, 32'h0000_4000, 32'h0);
        tick(); e1_valid = 1'b0;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        tests++; if (w_valid !== 1'b0 || stage_ready !== 1'b0) begin fails++; $display("FAIL flush_drain got v=%b rdy=%b exp 0/0", w_valid, stage_ready); end
        tick(); tick();
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF; tick(); rsp_valid = 1'b0;
        tests++; if (w_valid !== 1'b0 || stage_ready !== 1'b1) begin fails++; $display("FAIL flush_discard got v=%b rdy=%b exp 0/1", w_valid, stage_ready); end
        drive_op(OP_NONE, SZ_W, 1'b0, 5'd11, 32'h55, 32'h0);
        tick(); e1_valid = 1'b0;
        tests++; if (w_valid !== 1'b1 || w_rd_wdata !== 32'h55) begin fails++; $display("FAIL flush_next got v=%b d=%h exp 1/55", w_valid, w_rd_wdata); end
    endtask

    task automatic test_flush_req_and_stall();
        drive_op(OP_LOAD, SZ_W, 1'b0, 5'd12, 32'h0000_5000, 32'h0);
        tick(); e1_valid = 1'b0;
        flush = 1'b1; req_ready = 1'b1; #1;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL flush_req_drop got %b exp 0", req_valid); end
        tick(); flush = 1'b0; req_ready = 1'b0;
        tests++; if (stage_ready !== 1'b1 || w_valid !== 1'b0) begin fails++; $display("FAIL flush_req_idle got rdy=%b v=%b exp 1/0", stage_ready, w_valid); end
        stall = 1'b1; drive_op(OP_NONE, SZ_W, 1'b0, 5'd13, 32'h77, 32'h0);
        tick();
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL stall_bubble got %b exp 0", w_valid); end
        stall = 1'b0; tick(); e1_valid = 1'b0;
        tests++; if (w_valid !== 1'b1 || w_rd_wdata !== 32'h77) begin fails++; $display("FAIL stall_release got v=%b d=%h exp 1/77", w_valid, w_rd_wdata); end
        flush = 1'b1; drive_op(OP_NONE, SZ_W, 1'b0, 5'd14, 32'h88, 32'h0);
        tick(); flush = 1'b0; e1_valid = 1'b0;
        tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL flush_idle got %b exp 0", w_valid); end
    endtask

    task automatic test_misalign();
        drive_op(OP_LOAD, SZ_W, 1'b0, 5'd15, 32'h0000_3001, 32'h0);
        tick(); e1_valid = 1'b0;
`ifdef LETC_CORE_E2_MISALIGN_CHECK_EN
        tests++; if (w_valid !== 1'b1 || w_trap !== 1'b1 || w_rd_we !== 1'b0 || req_valid !== 1'b0)
            begin fails++; $display("FAIL misalign_trap got v=%b t=%b we=%b req=%b exp 1/1/0/0", w_valid, w_trap, w_rd_we, req_valid); end
`else
        tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_3000) begin fails++; $display("FAIL misalign_req got v=%b a=%h exp 1/3000", req_valid, req_addr); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D; tick(); rsp_valid = 1'b0;
        tests++; if (w_valid !== 1'b1 || w_trap !== 1'b0 || w_rd_wdata !== 32'hCAFE_F00D)
            begin fails++; $display("FAIL misalign_load got v=%b t=%b d=%h exp 1/0/cafef00d", w_valid, w_trap, w_rd_wdata); end
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        e1_valid = 1'b0; e1_rd_idx = '0; e1_rd_we = 1'b0; e1_alu = '0; e1_op = OP_NONE; e1_size = SZ_W;
        e1_uns = 1'b0; e1_sdata = '0; e1_csr_we = 1'b0; e1_csr_idx = '0; e1_csr_wdata = '0;
        test_reset();
        test_alu_passthrough();
        test_load(SZ_B, 1'b0, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        test_load(SZ_B, 1'b1, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        test_load(SZ_H, 1'b0, 32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001);
        test_load(SZ_H, 1'b1, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001);
        test_load(SZ_B, 1'b0, 32'h0000_1000, 32'h8001_127F, 32'h0000_007F);
        test_store(SZ_H, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        test_store(SZ_B, 32'h0000_2001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
        test_store(SZ_W, 32'h0000_2004, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);
        test_flush_wait_rsp();
        test_flush_req_and_stall();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
